// File: rtl/wb_gpio_capture.sv
// wb_gpio_capture: Wishbone GPIO port with synchronised inputs, per-pin edge capture,
// a saturating edge-event counter and a registered level interrupt.
module wb_gpio_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    inout  wire  [WIDTH-1:0] gpio_io,
    output logic             irq
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     out_q, dir_q, rise_en, fall_en, event_q, irq_en, prev, det;
    logic [WIDTH-1:0]     pin_s, edges, ev_clr, wdat;
    logic [CNT_WIDTH-1:0] count;
    logic [31:0]          rd;
    logic [2:0]           adr;
    logic                 req, wr;
    logic                 unused_ok;

    assign unused_ok = ^{wb_adr_i, wb_dat_i};
    assign pin_s     = sync_q[SYNC_STAGES-1];
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr        = req & wb_we_i;
    assign adr       = wb_adr_i[4:2];
    assign wdat      = wb_dat_i[WIDTH-1:0];
    assign edges     = dir_q & ((pin_s & ~prev & rise_en) | (~pin_s & prev & fall_en));
    assign ev_clr    = (wr && adr == 3'd5) ? wdat : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_io[i] = dir_q[i] ? 1'bz : out_q[i];
    end

    always_comb begin
        rd = '0;
        case (adr)
            3'd0: rd = 32'(pin_s);
            3'd1: rd = 32'(out_q);
            3'd2: rd = 32'(dir_q);
            3'd3: rd = 32'(rise_en);
            3'd4: rd = 32'(fall_en);
            3'd5: rd = 32'(event_q);
            3'd6: rd = 32'(irq_en);
            3'd7: rd = 32'(count);
        endcase
    end

    // prev follows the synchronised value every cycle, so a pin switched to input
    // starts from its current level and only later transitions count as edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '{default: '0};
            prev   <= '0;
            det    <= '0;
        end else begin
            sync_q[0] <= gpio_io;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev <= pin_s;
            det  <= edges;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            dir_q    <= '1;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_en   <= '0;
            event_q  <= '0;
            count    <= '0;
            irq      <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            out_q    <= (wr && adr == 3'd1) ? wdat : out_q;
            dir_q    <= (wr && adr == 3'd2) ? wdat : dir_q;
            rise_en  <= (wr && adr == 3'd3) ? wdat : rise_en;
            fall_en  <= (wr && adr == 3'd4) ? wdat : fall_en;
            irq_en   <= (wr && adr == 3'd6) ? wdat : irq_en;
            event_q  <= (event_q & ~ev_clr) | det;
            count    <= (wr && adr == 3'd7) ? CNT_WIDTH'(|det) :
                        (|det && count != CNT_MAX) ? count + 1'b1 : count;
            irq      <= |(event_q & irq_en);
            wb_ack_o <= req;
            wb_dat_o <= req ? rd : wb_dat_o;
        end
    end
endmodule

// File: tb/tb_wb_gpio_capture.sv
// tb_wb_gpio_capture: directed stimulus for wb_gpio_capture, checked every cycle against a
// behavioural model of the register map plus hand-computed register expectations.
module tb_wb_gpio_capture;
    localparam int W = 8, SS = 2, CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic         clk = 0, rst = 0;
    logic         cyc = 0, stb = 0, we = 0;
    logic [31:0]  adr = 0, dat_i = 0;
    wire  [31:0]  dat_o;
    wire          ack, irq;
    wire  [W-1:0] gpio;
    logic [W-1:0] drv = 0, tb_oe = '1;
    int           checks = 0, errors = 0;

    logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_ev, m_ien, dir_2, rise_2, fall_2;
    logic [W-1:0] sq[$];
    int           m_cnt;
    logic         m_ack, m_irq;
    logic [31:0]  m_dat;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign gpio[i] = tb_oe[i] ? drv[i] : 1'bz;
    end

    wb_gpio_capture #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .gpio_io(gpio), .irq(irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = '1; m_rise = '0; m_fall = '0; m_ev = '0; m_ien = '0;
        dir_2 = '1; rise_2 = '0; fall_2 = '0;
        m_cnt = 0; m_ack = 0; m_irq = 0; m_dat = '0;
        sq = {8'h00, 8'h00, 8'h00, 8'h00};
        tb_oe <= '1;
    endtask

    // One clock of the register map: a pin change sampled on edge n shows in EVENT
    // after edge n+SS+1, gated by the configuration of two edges earlier.
    task automatic model_step();
        logic [W-1:0] pin, det, wd, clr;
        logic [31:0]  rdv;
        logic [2:0]   a;
        logic         req, wr;
        pin = (m_dir & drv) | (~m_dir & m_out);
        req = cyc & stb & ~m_ack;
        wr  = req & we;
        a   = adr[4:2];
        wd  = dat_i[W-1:0];
        det = dir_2 & ((sq[2] & ~sq[3] & rise_2) | (~sq[2] & sq[3] & fall_2));
        rdv = '0;
        case (a)
            3'd0: rdv = 32'(sq[1]);
            3'd1: rdv = 32'(m_out);
            3'd2: rdv = 32'(m_dir);
            3'd3: rdv = 32'(m_rise);
            3'd4: rdv = 32'(m_fall);
            3'd5: rdv = 32'(m_ev);
            3'd6: rdv = 32'(m_ien);
            3'd7: rdv = 32'(m_cnt);
        endcase
        clr   = (wr && a == 3'd5) ? wd : '0;
        m_irq = |(m_ev & m_ien);
        m_ev  = (m_ev & ~clr) | det;
        if (wr && a == 3'd7) m_cnt = (det != 0) ? 1 : 0;
        else if (det != 0 && m_cnt < CMAX) m_cnt++;
        dir_2 = m_dir; rise_2 = m_rise; fall_2 = m_fall;
        if (wr) begin
            case (a)
                3'd1: m_out = wd;
                3'd2: m_dir = wd;
                3'd3: m_rise = wd;
                3'd4: m_fall = wd;
                3'd6: m_ien = wd;
                default: ;
            endcase
        end
        if (req) m_dat = rdv;
        m_ack = req;
        sq.push_front(pin);
        void'(sq.pop_back());
        tb_oe <= m_dir;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("ack", {31'd0, ack}, {31'd0, m_ack});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("dat_o", dat_o, m_dat);
        check("gpio", 32'(gpio), 32'((m_dir & drv) | (~m_dir & m_out)));
    end

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                       output logic [31:0] q);
        bit got = 0;
        cyc = 1; stb = 1; we = w; adr = {27'd0, a, 2'b00}; dat_i = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            got = ack;
        end
        q = dat_o;
        cyc = 0; stb = 0; we = 0;
        check("bus_ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] q;
        bus(1'b0, a, 32'd0, q);
        check(nm, q, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        idle(2);
        rd(0, 32'h00, "in_reset");  rd(1, 32'h00, "out_reset");
        rd(2, 32'hFF, "dir_reset"); rd(3, 32'h00, "rise_reset");
        rd(4, 32'h00, "fall_reset"); rd(5, 32'h00, "event_reset");
        rd(6, 32'h00, "irqen_reset"); rd(7, 32'h00, "count_reset");

        wr(2, 32'hF0); wr(1, 32'h05); idle(3);
        check("pins_low_nibble", {28'd0, gpio[3:0]}, 32'h5);
        rd(0, 32'h05, "in_low_nibble");

        wr(3, 32'hF0); drv = 8'hA0; idle(5);
        rd(5, 32'hA0, "event_rise_a0");
        rd(7, 32'd1, "count_one");

        wr(6, 32'h80); idle(2);
        check("irq_on", {31'd0, irq}, 32'd1);
        wr(5, 32'h80); idle(1);
        check("irq_off", {31'd0, irq}, 32'd0);
        rd(5, 32'h20, "event_after_w1c");

        wr(7, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drv[4] = 1; idle(4);
            drv[4] = 0; idle(4);
        end
        rd(7, 32'd3, "count_saturated");
        drv[4] = 1; idle(3);
        wr(7, 32'h0);
        rd(7, 32'd1, "count_write_with_edge");

        drv[4] = 0; idle(4);
        wr(5, 32'hFF);
        rd(5, 32'h00, "event_cleared");
        drv[4] = 1; idle(3);
        wr(5, 32'h10);
        rd(5, 32'h10, "event_set_priority");

        wr(5, 32'hFF); wr(4, 32'h40);
        drv[6] = 1; idle(4);
        drv[6] = 0; idle(5);
        rd(5, 32'h40, "event_rise_fall");

        drv[7] = 0; idle(4);
        wr(5, 32'hFF); idle(2);
        drv[7] = 1;
        lat = -1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (irq && lat < 0) lat = i;
        end
        check("irq_latency", 32'(lat), 32'd5);
        @(posedge clk); #1;

        drv = 8'h3C;
        cyc = 1; stb = 1; we = 1; adr = 32'h4; dat_i = 32'hFF;
        #2 rst = 0;
        #1 cyc = 0; stb = 0; we = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ack_after_reset", {31'd0, ack}, 32'd0);
        end
        @(posedge clk); #1;
        rd(0, 32'h3C, "in_after_reset"); rd(1, 32'h00, "out_after_reset");
        rd(2, 32'hFF, "dir_after_reset"); rd(3, 32'h00, "rise_after_reset");
        rd(4, 32'h00, "fall_after_reset"); rd(5, 32'h00, "event_after_reset");
        rd(6, 32'h00, "irqen_after_reset"); rd(7, 32'h00, "count_after_reset");

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
